// File: rtl/tsc_pkg.sv
// Shared types and constants for the TSC instruction fetch path.
package tsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam int WORD_SIZE         = 16;
  localparam int DEFAULT_PC_W      = 16;
  localparam int DEFAULT_HALT_ADDR = 27;

endpackage

// File: rtl/tsc_jump_target.sv
// Builds a JMP target by keeping the PC page bits and replacing the low 12 bits.
module tsc_jump_target #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-13:0] pc_upper,
  input  logic [11:0]      imm,
  output logic [PC_W-1:0]  target
);

  assign target = {pc_upper, imm};

endmodule

// File: rtl/tsc_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, single-entry instruction buffer.
// Optional macro TSC_FETCH_COUNT_EN adds the 16-bit accepted-instruction counter.
module tsc_fetch_unit
  import tsc_pkg::*;
#(
  parameter int PC_W      = DEFAULT_PC_W,
  parameter int INST_W    = WORD_SIZE,
  parameter int HALT_ADDR = DEFAULT_HALT_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              jump_valid,
  input  logic [11:0]       jump_imm,
  output logic [7:0]        pc_low8,
  output logic              halted,
  output logic [15:0]       fetch_count,
  output logic [1:0]        fsm_state
);

  // Handshakes: a memory transfer happens on a cycle with mem_req && mem_ack,
  // a decode transfer on a cycle with inst_valid && inst_ready. mem_req/mem_addr
  // and inst_valid/inst/inst_pc hold steady until their transfer completes.

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q;
  logic [PC_W-1:0]   inst_pc_q;
  logic              capture;
  logic [PC_W-1:0]   jump_target;
  logic              at_halt;

  tsc_jump_target #(.PC_W(PC_W)) u_jump_target (
    .pc_upper (pc_q[PC_W-1:12]),
    .imm      (jump_imm),
    .target   (jump_target)
  );

  assign at_halt = (inst_pc_q == PC_W'(HALT_ADDR));

  // In HOLD the PC already points past the buffered instruction, so a jump
  // takes its page bits from the incremented value.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ack) begin
          capture = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          if (at_halt) begin
            state_d = ST_HALT;
          end else begin
            if (jump_valid) pc_d = jump_target;
            state_d = enable ? ST_REQ : ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (capture) begin
        inst_q    <= mem_rdata;
        inst_pc_q <= pc_q;
      end
    end
  end

`ifdef TSC_FETCH_COUNT_EN
  logic [15:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else if (state_q == ST_HOLD && inst_ready) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

  assign mem_req    = (state_q == ST_REQ);
  assign mem_addr   = mem_req ? pc_q : '0;
  assign inst_valid = (state_q == ST_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign halted     = (state_q == ST_HALT);
  assign pc_low8    = pc_q[7:0];
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_tsc_fetch_unit.sv
// Directed bench for tsc_fetch_unit: a 16-bit PC instance plus a 13-bit PC instance for wrap.
// Expected fetch_count follows whether TSC_FETCH_COUNT_EN is defined.
module tb_tsc_fetch_unit;
  import tsc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        jump_valid = 1'b0;
  logic [11:0] jump_imm = '0;
  logic [7:0]  pc_low8;
  logic        halted;
  logic [15:0] fetch_count;
  logic [1:0]  fsm_state;

  logic        enable13 = 1'b0;
  logic        mem_req13;
  logic [12:0] mem_addr13;
  logic        mem_ack13 = 1'b0;
  logic [15:0] mem_rdata13 = '0;
  logic        inst_valid13;
  logic        inst_ready13 = 1'b0;
  logic [15:0] inst13;
  logic [12:0] inst_pc13;
  logic        jump_valid13 = 1'b0;
  logic [11:0] jump_imm13 = '0;
  logic [7:0]  pc_low8_13;
  logic        halted13;
  logic [15:0] fetch_count13;
  logic [1:0]  fsm_state13;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] exp_count = '0;

  tsc_fetch_unit #(.PC_W(16), .INST_W(16), .HALT_ADDR(27)) u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .jump_valid(jump_valid), .jump_imm(jump_imm), .pc_low8(pc_low8), .halted(halted),
    .fetch_count(fetch_count), .fsm_state(fsm_state)
  );

  tsc_fetch_unit #(.PC_W(13), .INST_W(16), .HALT_ADDR(27)) u_dut13 (
    .clk(clk), .reset(reset), .enable(enable13),
    .mem_req(mem_req13), .mem_addr(mem_addr13), .mem_ack(mem_ack13), .mem_rdata(mem_rdata13),
    .inst_valid(inst_valid13), .inst_ready(inst_ready13), .inst(inst13), .inst_pc(inst_pc13),
    .jump_valid(jump_valid13), .jump_imm(jump_imm13), .pc_low8(pc_low8_13), .halted(halted13),
    .fetch_count(fetch_count13), .fsm_state(fsm_state13)
  );

  // Clock / reset block
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    return 16'hC000 ^ addr;
  endfunction

  function automatic logic [15:0] exp_fc();
`ifdef TSC_FETCH_COUNT_EN
    return exp_count;
`else
    return 16'd0;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0; jump_valid = 1'b0;
    enable13 = 1'b0; mem_ack13 = 1'b0; inst_ready13 = 1'b0; jump_valid13 = 1'b0;
    step(); step();
    reset = 1'b0;
    exp_count = '0;
  endtask

  // Driver tasks for the 16-bit instance
  task automatic wait_req(input string name);
    int n = 0;
    while (mem_req !== 1'b1 && n < 12) begin step(); n++; end
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL %s: mem_req timeout actual=%b required=1", name, mem_req);
    end
  endtask

  task automatic fetch(input logic [15:0] addr, input int ack_delay);
    logic [15:0] nxt;
    nxt = addr + 16'd1;
    wait_req("fetch_wait");
    checks++;
    if (mem_addr !== addr) begin
      failures++; $display("FAIL fetch_addr: actual=%h required=%h", mem_addr, addr);
    end
    for (int i = 0; i < ack_delay; i++) begin
      step();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== addr || inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL req_stable: req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                 mem_req, mem_addr, inst_valid, addr);
      end
    end
    mem_ack = 1'b1; mem_rdata = mem_word(addr);
    step();
    mem_ack = 1'b0; mem_rdata = 16'($urandom_range(0, 16'hFFFF));
    checks++;
    if (inst_valid !== 1'b1 || inst !== mem_word(addr) || inst_pc !== addr) begin
      failures++;
      $display("FAIL capture: valid=%b inst=%h pc=%h required valid=1 inst=%h pc=%h",
               inst_valid, inst, inst_pc, mem_word(addr), addr);
    end
    checks++;
    if (pc_low8 !== nxt[7:0]) begin
      failures++; $display("FAIL pc_low8: actual=%h required=%h", pc_low8, nxt[7:0]);
    end
  endtask

  task automatic consume(input logic [15:0] addr, input int ready_delay,
                         input logic jv, input logic [11:0] imm);
    for (int i = 0; i < ready_delay; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst !== mem_word(addr) || inst_pc !== addr || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable: valid=%b inst=%h pc=%h req=%b required 1/%h/%h/0",
                 inst_valid, inst, inst_pc, mem_req, mem_word(addr), addr);
      end
    end
    inst_ready = 1'b1; jump_valid = jv; jump_imm = imm;
    step();
    inst_ready = 1'b0; jump_valid = 1'b0; jump_imm = '0;
    exp_count = exp_count + 16'd1;
    checks++;
    if (fetch_count !== exp_fc()) begin
      failures++; $display("FAIL fetch_count: actual=%0d required=%0d", fetch_count, exp_fc());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 16'd0 || inst_valid !== 1'b0 || inst !== 16'd0 ||
        inst_pc !== 16'd0 || halted !== 1'b0 || fetch_count !== 16'd0 || pc_low8 !== 8'd0 ||
        fsm_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: req=%b addr=%h valid=%b inst=%h pc=%h halt=%b fc=%h pcl=%h st=%0d required all 0",
               mem_req, mem_addr, inst_valid, inst, inst_pc, halted, fetch_count, pc_low8, fsm_state);
    end
    step(); step();
    checks++;
    if (mem_req !== 1'b0 || fsm_state !== ST_IDLE) begin
      failures++; $display("FAIL idle_no_enable: req=%b st=%0d required 0/0", mem_req, fsm_state);
    end
  endtask

  task automatic test_sequence();
    enable = 1'b1;
    for (int a = 0; a < 5; a++) begin
      fetch(16'(a), 1);
      consume(16'(a), 0, 1'b0, 12'h000);
    end
  endtask

  task automatic test_ack_delay();
    enable = 1'b0;
    fetch(16'd5, 3);
    consume(16'd5, 0, 1'b0, 12'h000);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
        failures++; $display("FAIL no_duplicate: valid=%b req=%b required 0/0", inst_valid, mem_req);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    int start;
    wait_req("b2b_start");
    start = cyc;
    for (int a = 6; a < 16; a++) begin
      fetch(16'(a), 0);
      consume(16'(a), 0, 1'b0, 12'h000);
    end
    checks++;
    if (cyc - start !== 20) begin
      failures++; $display("FAIL throughput: cycles=%0d required=20", cyc - start);
    end
  endtask

  task automatic test_hold_and_halt();
    fetch(16'd16, 1);
    consume(16'd16, 4, 1'b0, 12'h000);
    for (int a = 17; a < 28; a++) begin
      fetch(16'(a), 1);
      consume(16'(a), 0, 1'b0, 12'h000);
    end
    checks++;
    if (halted !== 1'b1 || inst_valid !== 1'b0 || pc_low8 !== 8'h1C) begin
      failures++;
      $display("FAIL halt_entry: halted=%b valid=%b pcl=%h required 1/0/1c", halted, inst_valid, pc_low8);
    end
    checks++;
    if (exp_count !== 16'd28 || fetch_count !== exp_fc()) begin
      failures++; $display("FAIL halt_count: actual=%0d required=%0d", fetch_count, exp_fc());
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (mem_req !== 1'b0 || halted !== 1'b1) begin
        failures++; $display("FAIL halt_stays: req=%b halted=%b required 0/1", mem_req, halted);
      end
    end
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    enable = 1'b1;
    wait_req("midreq_wait");
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || pc_low8 !== 8'd0 || inst !== 16'd0 || inst_pc !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_req: valid=%b pcl=%h inst=%h pc=%h required 0/00/0000/0000",
               inst_valid, pc_low8, inst, inst_pc);
    end
    exp_count = '0;
    fetch(16'd0, 1);
    consume(16'd0, 0, 1'b0, 12'h000);
  endtask

  task automatic test_jump();
    for (int a = 1; a < 16; a++) begin
      fetch(16'(a), 0);
      consume(16'(a), 0, 1'b0, 12'h000);
    end
    fetch(16'd16, 1);
    consume(16'd16, 4, 1'b1, 12'h015);
    // jump_valid raised while a request is pending must not move the PC
    jump_valid = 1'b1; jump_imm = 12'h0AA;
    fetch(16'd21, 2);
    jump_valid = 1'b0; jump_imm = '0;
    consume(16'd21, 0, 1'b0, 12'h000);
    fetch(16'd22, 0);
    consume(16'd22, 0, 1'b0, 12'h000);
  endtask

  task automatic fetch13(input logic [12:0] addr, input logic jv, input logic [11:0] imm);
    int n = 0;
    logic [12:0] nxt;
    nxt = addr + 13'd1;
    while (mem_req13 !== 1'b1 && n < 12) begin step(); n++; end
    checks++;
    if (mem_req13 !== 1'b1 || mem_addr13 !== addr) begin
      failures++; $display("FAIL w13_req: req=%b addr=%h required 1/%h", mem_req13, mem_addr13, addr);
    end
    mem_ack13 = 1'b1; mem_rdata13 = 16'h5000 ^ 16'(addr);
    step();
    mem_ack13 = 1'b0;
    checks++;
    if (inst_valid13 !== 1'b1 || inst_pc13 !== addr || pc_low8_13 !== nxt[7:0]) begin
      failures++;
      $display("FAIL w13_capture: valid=%b pc=%h pcl=%h required 1/%h/%h",
               inst_valid13, inst_pc13, pc_low8_13, addr, nxt[7:0]);
    end
    inst_ready13 = 1'b1; jump_valid13 = jv; jump_imm13 = imm;
    step();
    inst_ready13 = 1'b0; jump_valid13 = 1'b0; jump_imm13 = '0;
  endtask

  task automatic test_pc_wrap13();
    do_reset();
    enable13 = 1'b1;
    fetch13(13'h0000, 1'b1, 12'hFFF);
    fetch13(13'h0FFF, 1'b1, 12'hFFF);
    fetch13(13'h1FFF, 1'b0, 12'h000);
    fetch13(13'h0000, 1'b0, 12'h000);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ack_delay();
    test_back_to_back();
    test_hold_and_halt();
    test_reset_mid_req();
    test_jump();
    test_pc_wrap13();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
